uart_tx_engine: RTL and testbench

UART transmit engine, the serial-out counterpart of the board's receive shift register. It accepts a byte on a start/ready handshake and frames it as one 11-bit-time frame, sent LSB first on tx. The frame is: start bit, 7 or 8 data bits, optional parity, stop bit(s), with the baud rate chosen from a 12-entry table. It sits between the host-side register interface and the TX pin.

---
 rtl/uart_pkg.sv | 64 ++++++
 rtl/uart_tx_engine_if.sv | 32 +++
 rtl/uart_baud_gen.sv | 55 +++++
 rtl/uart_tx_engine.sv | 109 ++++++++++
 tb/tb_uart_tx_engine.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART transmit and receive paths.
//                Holds the baud-rate table and its select values, the frame
//                length, the transmitter state encoding, the divisor
//                calculation and the parity function.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Every frame occupies this many bit times; unused slots are sent as mark.
   localparam int unsigned FRAME_BITS = 11;

   // Baud select values
   localparam logic [3:0] BAUD_SEL_300    = 4'd0;
   localparam logic [3:0] BAUD_SEL_1200   = 4'd1;
   localparam logic [3:0] BAUD_SEL_2400   = 4'd2;
   localparam logic [3:0] BAUD_SEL_4800   = 4'd3;
   localparam logic [3:0] BAUD_SEL_9600   = 4'd4;
   localparam logic [3:0] BAUD_SEL_19200  = 4'd5;
   localparam logic [3:0] BAUD_SEL_38400  = 4'd6;
   localparam logic [3:0] BAUD_SEL_57600  = 4'd7;
   localparam logic [3:0] BAUD_SEL_115200 = 4'd8;
   localparam logic [3:0] BAUD_SEL_230400 = 4'd9;
   localparam logic [3:0] BAUD_SEL_460800 = 4'd10;
   localparam logic [3:0] BAUD_SEL_921600 = 4'd11;

   localparam int unsigned BAUD_NUM_RATES = 12;
   localparam int unsigned BAUD_RATES [BAUD_NUM_RATES] = '{
      300, 1200, 2400, 4800, 9600, 19200,
      38400, 57600, 115200, 230400, 460800, 921600
   };
   // Select values past the end of the table fall back to this rate.
   localparam int unsigned BAUD_DEFAULT = 115200;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tx_state_t;

   function automatic int unsigned baud_rate(input logic [3:0] sel);
      return ({28'd0, sel} < BAUD_NUM_RATES) ? BAUD_RATES[sel] : BAUD_DEFAULT;
   endfunction

   // Clocks per bit, rounded to nearest.
   function automatic int unsigned baud_divisor(input int unsigned clk_hz,
                                                input logic [3:0]  sel);
      int unsigned rate;
      rate = baud_rate(sel);
      return (clk_hz + rate / 2) / rate;
   endfunction

   // Even parity is the XOR of the active data bits, odd parity its inverse.
   function automatic logic parity(input logic [7:0] data,
                                   input logic       eight,
                                   input logic       odd);
      logic x;
      x = eight ? ^data : ^data[6:0];
      return x ^ odd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_engine_if
//  Description : Host-side handshake and line signals of the UART transmitter.
//                master : host side (drives byte, format, start request)
//                slave  : transmit engine (drives tx, tx_ready, tx_done)
//  Signals     : tx_data[7:0], tx_start, baud_sel[3:0], eight, pen, ohel
//                (host -> engine); tx, tx_ready, tx_done (engine -> host)
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_engine_if;
   logic [7:0] tx_data;
   logic       tx_start;
   logic [3:0] baud_sel;
   logic       eight;
   logic       pen;
   logic       ohel;
   logic       tx;
   logic       tx_ready;
   logic       tx_done;

   modport master (
      output tx_data, tx_start, baud_sel, eight, pen, ohel,
      input  tx, tx_ready, tx_done
   );

   modport slave (
      input  tx_data, tx_start, baud_sel, eight, pen, ohel,
      output tx, tx_ready, tx_done
   );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period timer. On i_clear the divisor for i_baud_sel is
//                latched and the count restarts; while i_en is high the
//                counter runs 0..D-1 and o_bit_tick is high in the last
//                clock of each bit period.
//  Ports       : clk, reset (async, active-high)
//                i_baud_sel[3:0] - rate index, used only on i_clear
//                i_clear         - restart counter and latch divisor
//                i_en            - count enable
//                o_bit_tick      - one-cycle end-of-bit strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned DIV_W  = 20
) (
   input  wire logic       clk,
   input  wire logic       reset,
   input  wire logic [3:0] i_baud_sel,
   input  wire logic       i_clear,
   input  wire logic       i_en,
   output logic            o_bit_tick
);

   // Terminal counts (D-1) for every select value, fixed at elaboration.
   logic [DIV_W-1:0] w_term_tab [16];
   logic [DIV_W-1:0] r_term;
   logic [DIV_W-1:0] r_cnt;
   logic             w_tick;

   for (genvar gi = 0; gi < 16; gi++) begin : g_term_tab
      assign w_term_tab[gi] = DIV_W'(baud_divisor(CLK_HZ, 4'(gi)) - 32'd1);
   end

   assign w_tick     = i_en && (r_cnt == r_term);
   assign o_bit_tick = w_tick;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_term <= '0;
         r_cnt  <= '0;
      end else if (i_clear) begin
         r_term <= w_term_tab[i_baud_sel];
         r_cnt  <= '0;
      end else if (i_en) begin
         r_cnt  <= w_tick ? '0 : r_cnt + DIV_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_engine
//  Description : UART transmitter. Accepts a byte on tx_start/tx_ready and
//                sends an 11-bit-time frame LSB first: start, 7 or 8 data
//                bits, optional parity, mark padding and stop.
//  Ports       : clk, reset (async, active-high)
//                bus (uart_tx_engine_if.slave): tx_data, tx_start, baud_sel,
//                eight, pen, ohel in; tx, tx_ready, tx_done out
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned DIV_W  = 20
) (
   input wire logic        clk,
   input wire logic        reset,
   uart_tx_engine_if.slave bus
);

   tx_state_t             r_state;
   tx_state_t             w_state_nxt;
   logic [FRAME_BITS-1:0] r_shift;
   logic [3:0]            r_bit;
   logic [FRAME_BITS-1:0] w_frame;
   logic                  w_par;
   logic                  w_tick;
   logic                  w_last;
   logic                  w_accept;
   logic                  w_ready;
   logic                  w_done;

   assign w_par   = parity(bus.tx_data, bus.eight, bus.ohel);
   // {b10 .. b0}; slots not used by data or parity are mark.
   assign w_frame = {1'b1,
                     bus.eight ? (bus.pen ? w_par : 1'b1) : 1'b1,
                     bus.eight ? bus.tx_data[7] : (bus.pen ? w_par : 1'b1),
                     bus.tx_data[6:0],
                     1'b0};

   assign w_last = (r_bit == 4'(FRAME_BITS - 1));

   uart_baud_gen #(
      .CLK_HZ (CLK_HZ),
      .DIV_W  (DIV_W)
   ) u_baud_gen (
      .clk        (clk),
      .reset      (reset),
      .i_baud_sel (bus.baud_sel),
      .i_clear    (w_accept),
      .i_en       (r_state == SHIFT),
      .o_bit_tick (w_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // The last clock of the stop bit doubles as an accept window so that a
   // waiting byte follows with no idle gap on the line.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            w_ready = 1'b1;
            if (bus.tx_start) begin
               w_accept    = 1'b1;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (w_tick && w_last) begin
               w_done  = 1'b1;
               w_ready = 1'b1;
               if (bus.tx_start) w_accept    = 1'b1;
               else              w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The line is driven straight from r_shift[0]; the register rests at
   // all-ones so the idle line is mark.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift <= '1;
         r_bit   <= '0;
      end else if (w_accept) begin
         r_shift <= w_frame;
         r_bit   <= '0;
      end else if (w_tick) begin
         r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
         r_bit   <= r_bit + 4'd1;
      end
   end

   assign bus.tx       = r_shift[0];
   assign bus.tx_ready = w_ready;
   assign bus.tx_done  = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_engine
//  Description : Self-checking bench for uart_tx_engine. Two instances: one
//                at CLK_HZ=1_152_000 (115200 baud -> 10 clocks per bit) for
//                frame tests, one at CLK_HZ=100_000_000 for divisor checks.
//                Outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

   localparam int unsigned CLK_A = 1_152_000;
   localparam int unsigned CLK_B = 100_000_000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_tx_engine_if if_a ();
   uart_tx_engine_if if_b ();

   uart_tx_engine #(.CLK_HZ(CLK_A), .DIV_W(20)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (if_a)
   );

   uart_tx_engine #(.CLK_HZ(CLK_B), .DIV_W(20)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (if_b)
   );

   int checks = 0;
   int errors = 0;

   logic obs_tx[$], obs_done[$], obs_rdy[$];
   logic exp_tx[$], exp_done[$], exp_rdy[$];

   // ---------------- reference model ----------------
   function automatic int model_div(input int unsigned clk_hz, input int sel);
      real r;
      case (sel)
         0: r = 300.0;     1: r = 1200.0;    2: r = 2400.0;    3: r = 4800.0;
         4: r = 9600.0;    5: r = 19200.0;   6: r = 38400.0;   7: r = 57600.0;
         8: r = 115200.0;  9: r = 230400.0;  10: r = 460800.0; 11: r = 921600.0;
         default: r = 115200.0;
      endcase
      return $rtoi(real'(clk_hz) / r + 0.5);
   endfunction

   function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit e, p, o);
      int ones;
      bit par;
      logic [10:0] f;
      ones = 0;
      for (int i = 0; i < (e ? 8 : 7); i++) ones += int'(d[i]);
      par = o ? (ones % 2 == 0) : (ones % 2 == 1);
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 7; i++) f[1+i] = d[i];
      if (e) begin
         f[8] = d[7];
         if (p) f[9] = par;
      end else if (p) begin
         f[8] = par;
      end
      return f;
   endfunction

   task automatic model_frame(input logic [10:0] f, input int d);
      for (int b = 0; b < 11; b++)
         for (int c = 0; c < d; c++) begin
            exp_tx.push_back(f[b]);
            exp_done.push_back(b == 10 && c == d - 1);
            exp_rdy.push_back(b == 10 && c == d - 1);
         end
   endtask

   task automatic model_idle(input int n);
      repeat (n) begin
         exp_tx.push_back(1'b1);
         exp_done.push_back(1'b0);
         exp_rdy.push_back(1'b1);
      end
   endtask

   // ---------------- capture utilities ----------------
   task automatic clear_waves();
      obs_tx.delete(); obs_done.delete(); obs_rdy.delete();
      exp_tx.delete(); exp_done.delete(); exp_rdy.delete();
   endtask

   task automatic capture_a(input int n);
      repeat (n) begin
         obs_tx.push_back(if_a.tx);
         obs_done.push_back(if_a.tx_done);
         obs_rdy.push_back(if_a.tx_ready);
         @(negedge clk);
      end
   endtask

   // Leaves the bench at the first falling edge after the accepting edge.
   task automatic start_a(input logic [7:0] d, input logic e, p, o, input logic [3:0] sel);
      if_a.tx_data  = d;
      if_a.eight    = e;
      if_a.pen      = p;
      if_a.ohel     = o;
      if_a.baud_sel = sel;
      if_a.tx_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic int wave_mismatches(output int first);
      int n;
      n = 0;
      first = 0;
      if (obs_tx.size() != exp_tx.size()) return 100000 + obs_tx.size();
      first = -1;
      foreach (exp_tx[i])
         if (obs_tx[i] !== exp_tx[i] || obs_done[i] !== exp_done[i] || obs_rdy[i] !== exp_rdy[i]) begin
            if (first < 0) first = i;
            n++;
         end
      if (first < 0) first = 0;
      return n;
   endfunction

   function automatic int count_done();
      int n;
      n = 0;
      foreach (obs_done[i]) if (obs_done[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int first_done();
      foreach (obs_done[i]) if (obs_done[i] === 1'b1) return i;
      return -1;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      int bad_tx, bad_rdy, bad_done;
      bad_tx = 0; bad_rdy = 0; bad_done = 0;
      reset = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++;
      if ({if_a.tx, if_a.tx_ready, if_a.tx_done} !== 3'b110) begin
         errors++;
         $display("FAIL reset_state_a: tx/ready/done got %b%b%b want 110", if_a.tx, if_a.tx_ready, if_a.tx_done);
      end
      checks++;
      if ({if_b.tx, if_b.tx_ready, if_b.tx_done} !== 3'b110) begin
         errors++;
         $display("FAIL reset_state_b: tx/ready/done got %b%b%b want 110", if_b.tx, if_b.tx_ready, if_b.tx_done);
      end
      reset = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (if_a.tx !== 1'b1 || if_b.tx !== 1'b1) bad_tx++;
         if (if_a.tx_ready !== 1'b1 || if_b.tx_ready !== 1'b1) bad_rdy++;
         if (if_a.tx_done !== 1'b0 || if_b.tx_done !== 1'b0) bad_done++;
      end
      checks++;
      if (bad_tx !== 0) begin errors++; $display("FAIL idle_tx: %0d cycles with tx!=1, want 0", bad_tx); end
      checks++;
      if (bad_rdy !== 0) begin errors++; $display("FAIL idle_ready: %0d cycles with tx_ready!=1, want 0", bad_rdy); end
      checks++;
      if (bad_done !== 0) begin errors++; $display("FAIL idle_done: %0d cycles with tx_done!=0, want 0", bad_done); end
   endtask

   task automatic test_reset_midframe();
      start_a(8'h00, 1'b1, 1'b0, 1'b0, 4'd8);
      if_a.tx_start = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if ({if_a.tx, if_a.tx_ready} !== 2'b00) begin
         errors++;
         $display("FAIL midframe_busy: tx/ready got %b%b want 00", if_a.tx, if_a.tx_ready);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({if_a.tx, if_a.tx_ready, if_a.tx_done} !== 3'b110) begin
         errors++;
         $display("FAIL reset_abort: tx/ready/done got %b%b%b want 110", if_a.tx, if_a.tx_ready, if_a.tx_done);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({if_a.tx, if_a.tx_ready, if_a.tx_done} !== 3'b110) begin
         errors++;
         $display("FAIL reset_after: tx/ready/done got %b%b%b want 110", if_a.tx, if_a.tx_ready, if_a.tx_done);
      end
   endtask

   task automatic test_frame_55();
      int d, nbad, first;
      d = model_div(CLK_A, 8);
      clear_waves();
      start_a(8'h55, 1'b1, 1'b0, 1'b0, 4'd8);
      if_a.tx_start = 1'b0;
      capture_a(11 * d + 10);
      model_frame(frame_bits(8'h55, 1, 0, 0), d);
      model_idle(10);
      nbad = wave_mismatches(first);
      checks++;
      if (nbad != 0) begin
         errors++;
         $display("FAIL frame55_wave: %0d bad samples, first %0d got tx/done/rdy %b%b%b want %b%b%b",
                  nbad, first, obs_tx[first], obs_done[first], obs_rdy[first],
                  exp_tx[first], exp_done[first], exp_rdy[first]);
      end
      checks++;
      if (first_done() != 11 * d - 1) begin
         errors++;
         $display("FAIL frame55_done_time: got sample %0d want %0d", first_done(), 11 * d - 1);
      end
      checks++;
      if (count_done() != 1) begin
         errors++;
         $display("FAIL frame55_done_count: got %0d want 1", count_done());
      end
   endtask

   task automatic test_parity_41();
      int d, nbad, first;
      d = model_div(CLK_A, 8);
      for (int o = 0; o < 2; o++) begin
         clear_waves();
         start_a(8'h41, 1'b0, 1'b1, 1'(o), 4'd8);
         if_a.tx_start = 1'b0;
         capture_a(11 * d + 10);
         model_frame(frame_bits(8'h41, 0, 1, 1'(o)), d);
         model_idle(10);
         nbad = wave_mismatches(first);
         checks++;
         if (nbad != 0) begin
            errors++;
            $display("FAIL parity41_wave ohel=%0d: %0d bad samples, first %0d got tx %b want %b",
                     o, nbad, first, obs_tx[first], exp_tx[first]);
         end
         checks++;
         if (obs_tx[8 * d + d / 2] !== 1'(o)) begin
            errors++;
            $display("FAIL parity41_b8 ohel=%0d: got %b want %0d", o, obs_tx[8 * d + d / 2], o);
         end
      end
   endtask

   task automatic test_a5_midchange();
      int d, nbad, first;
      d = model_div(CLK_A, 8);
      clear_waves();
      start_a(8'hA5, 1'b1, 1'b1, 1'b1, 4'd8);
      if_a.tx_start = 1'b0;
      capture_a(35);
      if_a.baud_sel = 4'd0;
      if_a.pen      = 1'b0;
      if_a.eight    = 1'b0;
      if_a.ohel     = 1'b0;
      if_a.tx_data  = 8'h3C;
      capture_a(11 * d + 10 - 35);
      model_frame(frame_bits(8'hA5, 1, 1, 1), d);
      model_idle(10);
      nbad = wave_mismatches(first);
      checks++;
      if (nbad != 0) begin
         errors++;
         $display("FAIL a5_midchange_wave: %0d bad samples, first %0d got tx %b want %b",
                  nbad, first, obs_tx[first], exp_tx[first]);
      end
      checks++;
      if ({obs_tx[8 * d + d / 2], obs_tx[9 * d + d / 2]} !== 2'b11) begin
         errors++;
         $display("FAIL a5_b8b9: got %b%b want 11", obs_tx[8 * d + d / 2], obs_tx[9 * d + d / 2]);
      end
   endtask

   task automatic test_back_to_back();
      int d, nbad, first, second_start;
      d = model_div(CLK_A, 8);
      clear_waves();
      start_a(8'h01, 1'b1, 1'b0, 1'b0, 4'd8);
      // tx_start stays high across the whole first frame.
      capture_a(11 * d - 1);
      if_a.tx_data = 8'h80;
      capture_a(2);
      if_a.tx_start = 1'b0;
      capture_a(11 * d + 20 - 1);
      model_frame(frame_bits(8'h01, 1, 0, 0), d);
      model_frame(frame_bits(8'h80, 1, 0, 0), d);
      model_idle(20);
      nbad = wave_mismatches(first);
      checks++;
      if (nbad != 0) begin
         errors++;
         $display("FAIL b2b_wave: %0d bad samples, first %0d got tx/done/rdy %b%b%b want %b%b%b",
                  nbad, first, obs_tx[first], obs_done[first], obs_rdy[first],
                  exp_tx[first], exp_done[first], exp_rdy[first]);
      end
      checks++;
      if (count_done() != 2) begin
         errors++;
         $display("FAIL b2b_done_count: got %0d want 2", count_done());
      end
      second_start = -1;
      for (int i = 11 * d - 1; i < obs_tx.size(); i++)
         if (obs_tx[i] === 1'b0) begin second_start = i; break; end
      checks++;
      if (second_start != 11 * d) begin
         errors++;
         $display("FAIL b2b_gap: second start bit at sample %0d want %0d", second_start, 11 * d);
      end
   endtask

   task automatic test_random();
      int d, nbad, first;
      logic [7:0] data;
      bit e, p, o;
      logic [3:0] sel;
      for (int it = 0; it < 6; it++) begin
         data = 8'($urandom);
         e    = 1'($urandom);
         p    = 1'($urandom);
         o    = 1'($urandom);
         sel  = ($urandom_range(0, 1) == 1) ? 4'd8 : 4'd15;
         d    = model_div(CLK_A, int'(sel));
         clear_waves();
         start_a(data, e, p, o, sel);
         if_a.tx_start = 1'b0;
         capture_a(40);
         if_a.tx_data  = 8'($urandom);
         if_a.eight    = 1'($urandom);
         if_a.pen      = 1'($urandom);
         if_a.ohel     = 1'($urandom);
         if_a.baud_sel = 4'($urandom);
         if_a.tx_start = 1'($urandom);
         capture_a(40);
         if_a.tx_start = 1'b0;
         capture_a(11 * d + 10 - 80);
         model_frame(frame_bits(data, e, p, o), d);
         model_idle(10);
         nbad = wave_mismatches(first);
         checks++;
         if (nbad != 0) begin
            errors++;
            $display("FAIL random_wave it=%0d data=%h e=%0d p=%0d o=%0d: %0d bad, first %0d got tx %b want %b",
                     it, data, e, p, o, nbad, first, obs_tx[first], exp_tx[first]);
         end
      end
   endtask

   task automatic measure_width(input bit use_b, input logic [3:0] sel, output int width);
      if (use_b) begin
         if_b.tx_data = 8'hFF; if_b.eight = 1'b1; if_b.pen = 1'b0; if_b.ohel = 1'b0;
         if_b.baud_sel = sel;  if_b.tx_start = 1'b1;
      end else begin
         if_a.tx_data = 8'hFF; if_a.eight = 1'b1; if_a.pen = 1'b0; if_a.ohel = 1'b0;
         if_a.baud_sel = sel;  if_a.tx_start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if_a.tx_start = 1'b0;
      if_b.tx_start = 1'b0;
      width = 0;
      while (((use_b ? if_b.tx : if_a.tx) === 1'b0) && width < 20000) begin
         width++;
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_baud_sweep();
      int w;
      bit   use_b [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int   sels  [5] = '{0, 11, 15, 4, 13};
      for (int k = 0; k < 5; k++) begin
         measure_width(use_b[k], 4'(sels[k]), w);
         checks++;
         if (w != model_div(use_b[k] ? CLK_B : CLK_A, sels[k])) begin
            errors++;
            $display("FAIL bit_width dut_%s sel=%0d: got %0d clocks want %0d",
                     use_b[k] ? "b" : "a", sels[k], w, model_div(use_b[k] ? CLK_B : CLK_A, sels[k]));
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      if_a.tx_data = '0; if_a.tx_start = 1'b0; if_a.baud_sel = 4'd8;
      if_a.eight = 1'b1; if_a.pen = 1'b0; if_a.ohel = 1'b0;
      if_b.tx_data = '0; if_b.tx_start = 1'b0; if_b.baud_sel = 4'd8;
      if_b.eight = 1'b1; if_b.pen = 1'b0; if_b.ohel = 1'b0;
      test_reset();
      test_reset_midframe();
      test_frame_55();
      test_parity_41();
      test_a5_midchange();
      test_back_to_back();
      test_random();
      test_baud_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      errors++;
      $display("FAIL watchdog: got timeout want completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
